// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC fetch path.
package npc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    RD   = 2'd2,
    OUT  = 2'd3
  } ifu_state_e;

  // Next-PC source selected by the fetch FSM.
  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2,
    PC_PEND  = 2'd3
  } pc_sel_e;

  localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  function automatic logic resp_is_fault(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/ifu_pc_gen.sv
// Fetch PC register plus the pending redirect target that is applied once
// a dropped read response has drained.
module ifu_pc_gen
  import npc_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  pc_sel_e           pc_sel,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pend_pc;

  // PC and pending-target registers; the newest redirect always overwrites the pending target.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      pend_pc <= RESET_PC;
    end else begin
      if (pend_set) begin
        pend_pc <= redirect_pc;
      end
      case (pc_sel)
        PC_INC:   pc <= pc + ADDR_W'(4);
        PC_REDIR: pc <= redirect_pc;
        PC_PEND:  pc <= pend_pc;
        default:  pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: AXI-lite read master towards the instruction SRAM,
// valid/ready producer of {inst_pc, inst} towards the IDU, redirect sink from EXU.
// Optional performance counters are enabled with `define IFU_PERF_EN.
module ifu_fetch
  import npc_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  ifu_state_e        state, state_next;
  logic              drop, drop_next;
  logic              latch;
  logic              pend_set;
  pc_sel_e           pc_sel;
  logic [ADDR_W-1:0] pc;

  ifu_pc_gen #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk         (clk),
    .rst         (rst),
    .pc_sel      (pc_sel),
    .pend_set    (pend_set),
    .redirect_pc (redirect_pc),
    .pc          (pc)
  );

  // State, drop flag and the instruction holding registers presented to the IDU.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      drop       <= 1'b0;
      inst       <= DATA_W'(INST_NOP);
      inst_pc    <= RESET_PC;
      inst_fault <= 1'b0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
      if (latch) begin
        inst       <= rdata;
        inst_pc    <= pc;
        inst_fault <= resp_is_fault(rresp);
      end
    end
  end

  // Next-state and PC selection; a redirect outranks every same-cycle handshake.
  // A redirect seen in RD is parked as the pending target (like one seen in AR)
  // and installed when the dropped response drains, so araddr/inst_pc match a direct pc load.
  always_comb begin
    state_next = state;
    drop_next  = drop;
    pc_sel     = PC_HOLD;
    pend_set   = 1'b0;
    latch      = 1'b0;
    case (state)
      IDLE: begin
        state_next = AR;
        if (redirect_valid) begin
          pc_sel = PC_REDIR;
        end
      end
      AR: begin
        if (redirect_valid) begin
          drop_next = 1'b1;
          pend_set  = 1'b1;
        end
        if (arready) begin
          state_next = RD;
        end
      end
      RD: begin
        if (rvalid) begin
          state_next = AR;
          drop_next  = 1'b0;
          if (redirect_valid) begin
            pc_sel = PC_REDIR;
          end else if (drop) begin
            pc_sel = PC_PEND;
          end else begin
            latch      = 1'b1;
            state_next = OUT;
          end
        end else if (redirect_valid) begin
          drop_next = 1'b1;
          pend_set  = 1'b1;
        end
      end
      OUT: begin
        if (redirect_valid) begin
          pc_sel     = PC_REDIR;
          state_next = AR;
        end else if (inst_ready) begin
          pc_sel     = PC_INC;
          state_next = AR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign araddr     = pc;
  assign arvalid    = (state == AR);
  assign rready     = (state == RD);
  assign inst_valid = (state == OUT);

`ifdef IFU_PERF_EN
  // Delivered-instruction and memory-wait cycle counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pc_sel == PC_INC) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (state == AR || state == RD) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: behavioural SRAM slave, random IDU backpressure and
// EXU redirects, with a scoreboard predicting the delivered instruction stream.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .araddr         (araddr),
    .arvalid        (arvalid),
    .arready        (arready),
    .rdata          (rdata),
    .rresp          (rresp),
    .rvalid         (rvalid),
    .rready         (rready),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef IFU_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned n_deliv = 0;

  // Expected PC of the next instruction the IDU should accept.
  logic [31:0] exp_q[$];
  logic [31:0] ar_log[$];

  // Stimulus knobs
  logic        rst_req = 1'b1;
  int unsigned rdy_mode = 1;      // 0 random, 1 always, 2 never
  logic        stall_en = 1'b0;
  logic        lat_rand = 1'b0;
  logic        redir_en = 1'b0;
  logic        force_redir = 1'b0;
  logic [31:0] force_target = '0;
  logic        log_ar = 1'b0;

  // Slave state
  logic        busy = 1'b0;
  int unsigned cnt = 0;
  logic [31:0] saddr = '0;
  logic        first_ar = 1'b0;

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic fault_of(input logic [31:0] a);
    return a[6:2] == 5'd2;
  endfunction

  function automatic logic [31:0] rand_target();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFF8;
    return 32'h8000_0000 + ($urandom_range(0, 255) << 2);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus, driven at the falling edge.
  task automatic step();
    @(negedge clk);
    if (rst) begin
      busy = 1'b0;
      cnt  = 0;
      first_ar = 1'b1;
      chk("rst_arvalid", 64'(arvalid), 64'd0);
      chk("rst_rready", 64'(rready), 64'd0);
      chk("rst_inst_valid", 64'(inst_valid), 64'd0);
      chk("rst_inst", 64'(inst), 64'(NOP));
      chk("rst_inst_pc", 64'(inst_pc), 64'(RST_PC));
      chk("rst_inst_fault", 64'(inst_fault), 64'd0);
    end
    rst = rst_req;
    if (busy && cnt != 0) cnt--;
    rvalid  = busy && (cnt == 0);
    rdata   = mem_of(saddr);
    rresp   = fault_of(saddr) ? 2'b10 : 2'b00;
    arready = !busy && (!stall_en || $urandom_range(0, 3) != 0);
    case (rdy_mode)
      1:       inst_ready = 1'b1;
      2:       inst_ready = 1'b0;
      default: inst_ready = ($urandom_range(0, 2) != 0);
    endcase
    redirect_valid = 1'b0;
    if (!rst) begin
      if (force_redir) begin
        redirect_valid = 1'b1;
        redirect_pc    = force_target;
        force_redir    = 1'b0;
      end else if (redir_en && $urandom_range(0, 19) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = rand_target();
      end
    end
    if (rst) begin
      exp_q.delete();
      exp_q.push_back(RST_PC);
    end else begin
      if (redirect_valid) begin
        exp_q.delete();
        exp_q.push_back(redirect_pc);
      end
      if (arvalid && arready) begin
        busy  = 1'b1;
        saddr = araddr;
        cnt   = lat_rand ? $urandom_range(1, 3) : 2;
        if (log_ar) ar_log.push_back(araddr);
        if (first_ar) chk("first_araddr", 64'(araddr), 64'(RST_PC));
        first_ar = 1'b0;
      end
      if (redirect_valid) first_ar = 1'b0;
      if (rvalid && rready) busy = 1'b0;
    end
  endtask

  // Monitor: protocol invariants and scoreboard on every accepted instruction.
  initial begin
    logic        hold_out = 1'b0;
    logic        hold_ar  = 1'b0;
    logic [31:0] p_inst = '0, p_pc = '0, p_addr = '0, e_pc;
    logic        p_fault = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        hold_out = 1'b0;
        hold_ar  = 1'b0;
      end else begin
        chk("one_hot", 64'(32'(arvalid) + 32'(rready) + 32'(inst_valid) <= 1), 64'd1);
        if (hold_out) begin
          chk("out_hold_valid", 64'(inst_valid), 64'd1);
          chk("out_hold_inst", 64'(inst), 64'(p_inst));
          chk("out_hold_pc", 64'(inst_pc), 64'(p_pc));
          chk("out_hold_fault", 64'(inst_fault), 64'(p_fault));
        end
        if (hold_ar) begin
          chk("ar_hold_valid", 64'(arvalid), 64'd1);
          chk("ar_hold_addr", 64'(araddr), 64'(p_addr));
        end
        if (inst_valid && inst_ready && !redirect_valid) begin
          if (exp_q.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
          end else begin
            e_pc = exp_q.pop_front();
            chk("inst_pc", 64'(inst_pc), 64'(e_pc));
            chk("inst", 64'(inst), 64'(mem_of(e_pc)));
            chk("inst_fault", 64'(inst_fault), 64'(fault_of(e_pc)));
            exp_q.push_back(e_pc + 32'd4);
            n_deliv++;
          end
        end
        hold_out = inst_valid && !inst_ready && !redirect_valid;
        hold_ar  = arvalid && !arready;
        p_inst = inst; p_pc = inst_pc; p_fault = inst_fault; p_addr = araddr;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_for(input string name, input int sel);
    int unsigned i;
    logic hit;
    i = 0;
    hit = 1'b0;
    while (i < 80 && !hit) begin
      hit = (sel == 0) ? rready : inst_valid;
      if (!hit) begin
        step();
        i++;
      end
    end
    chk(name, 64'(hit), 64'd1);
  endtask

  initial begin
    // Basic sequential fetch after a 2-cycle reset.
    rst_req = 1'b1;
    step(); step();
    rst_req = 1'b0;
    log_ar  = 1'b1;
    repeat (40) step();
    log_ar  = 1'b0;
    chk("ar_log_len", 64'(ar_log.size() >= 3), 64'd1);
    if (ar_log.size() >= 3) begin
      chk("ar_seq0", 64'(ar_log[0]), 64'h8000_0000);
      chk("ar_seq1", 64'(ar_log[1]), 64'h8000_0004);
      chk("ar_seq2", 64'(ar_log[2]), 64'h8000_0008);
    end

    // IDU backpressure for 5 cycles in OUT.
    rdy_mode = 2;
    wait_for("wait_out_hold", 1);
    repeat (5) step();
    chk("hold_no_ar", 64'(arvalid), 64'd0);
    chk("hold_valid", 64'(inst_valid), 64'd1);
    rdy_mode = 1;
    repeat (10) step();

    // Redirect while waiting for read data; 0x108 then returns a fault.
    wait_for("wait_rd", 0);
    force_target = 32'h8000_0100;
    force_redir  = 1'b1;
    repeat (30) step();

    // Redirect coinciding with the OUT handshake.
    rdy_mode = 2;
    wait_for("wait_out_redir", 1);
    rdy_mode = 1;
    force_target = 32'h8000_0200;
    force_redir  = 1'b1;
    repeat (20) step();

    // Reset while in RD.
    wait_for("wait_rd_rst", 0);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    repeat (20) step();

    // Random traffic: backpressure, slave stalls, variable latency, redirects.
    rdy_mode = 0;
    stall_en = 1'b1;
    lat_rand = 1'b1;
    redir_en = 1'b1;
    repeat (3000) step();

    // A second mid-stream reset under random traffic.
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    repeat (1000) step();

    redir_en = 1'b0;
    rdy_mode = 1;
    repeat (30) step();
    chk("deliveries", 64'(n_deliv > 200), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
